// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_signed_divider_pkg;

  // Default operand width.
  localparam int unsigned DIV_N = 32;

  // Controller states: waiting for a start, one restoring step per cycle, sign fix-up/writeback.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/registerNbits.sv
// N-bit register with synchronous active-high clear and load enable.
// Latency: one cycle from i_d to o_q when i_en is high.
// Backpressure: holds its value while i_en is low.
module registerNbits #(
  parameter int unsigned N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  // Clear has priority over the load enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/twos_negate.sv
// Conditional two's-complement negate: out = neg ? -in : in.
// Latency: combinational.
// Backpressure: none.
module twos_negate #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] in_val,
  output logic [W-1:0] out_val
);

  // The most negative value maps onto itself, which reads correctly as the unsigned magnitude 2^(W-1).
  assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/seq_signed_divider.sv
// Radix-2 restoring signed divider on sign-magnitude operands, one quotient bit per enabled cycle.
// Latency: o_valid rises N+1 enabled cycles after the accepting edge, including divide-by-zero.
// Backpressure: none on the result; i_start is ignored while busy and i_en low freezes everything.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_valid,
  output logic         o_div_by_zero,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder
);

  localparam int unsigned CW = $clog2(N + 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic          dz_q, dz_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  raw_dvd_q, raw_dvd_d;
  // Starts as |dividend| and fills with quotient bits from the LSB as the MSBs shift out.
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  dsr_q, dsr_d;
  logic [N:0]    rem_q, rem_d;

  logic          accept;
  logic          out_we;
  logic [N-1:0]  dvd_mag, dsr_mag;
  logic [N-1:0]  quo_fix, rem_fix;
  logic [N-1:0]  quo_res, rem_res;
  logic [N+1:0]  rem_diff;

  // Operand magnitudes straight from the ports so they can be latched on the accepting edge.
  twos_negate #(.W(N)) u_abs_dvd (
    .neg     (i_dividend[N-1]),
    .in_val  (i_dividend),
    .out_val (dvd_mag)
  );

  twos_negate #(.W(N)) u_abs_dsr (
    .neg     (i_divisor[N-1]),
    .in_val  (i_divisor),
    .out_val (dsr_mag)
  );

  // Result sign fix-up: quotient follows sign(a)^sign(b), remainder follows the dividend.
  twos_negate #(.W(N)) u_neg_quo (
    .neg     (neg_quo_q),
    .in_val  (quo_q),
    .out_val (quo_fix)
  );

  twos_negate #(.W(N)) u_neg_rem (
    .neg     (neg_rem_q),
    .in_val  (rem_q[N-1:0]),
    .out_val (rem_fix)
  );

  // Divide-by-zero overrides the arithmetic result with all-ones / raw dividend.
  assign quo_res = dz_q ? '1 : quo_fix;
  assign rem_res = dz_q ? raw_dvd_q : rem_fix;

  // Trial subtract of the shifted partial remainder; the extra top bit is the borrow.
  assign rem_diff = {rem_q, quo_q[N-1]} - {2'b00, dsr_q};

  // Next-state and control strobes for the IDLE -> ITER -> FIX sequence.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    out_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ITER;
          accept  = 1'b1;
        end
      end
      ST_ITER: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        out_we  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, then one restoring step per ITER cycle.
  always_comb begin
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    raw_dvd_d = raw_dvd_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    valid_d   = (state_q == ST_FIX);
    if (accept) begin
      neg_quo_d = i_dividend[N-1] ^ i_divisor[N-1];
      neg_rem_d = i_dividend[N-1];
      dz_d      = (i_divisor == '0);
      raw_dvd_d = i_dividend;
      quo_d     = dvd_mag;
      dsr_d     = dsr_mag;
      rem_d     = '0;
      cnt_d     = '0;
    end else if (state_q == ST_ITER) begin
      // Borrow set: restore the shifted value and record a 0 quotient bit.
      rem_d = rem_diff[N+1] ? {rem_q[N-1:0], quo_q[N-1]} : rem_diff[N:0];
      quo_d = {quo_q[N-2:0], ~rem_diff[N+1]};
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers: reset wins over enable, otherwise everything holds while i_en is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      valid_q   <= 1'b0;
      raw_dvd_q <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
    end else if (i_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      valid_q   <= valid_d;
      raw_dvd_q <= raw_dvd_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
    end
  end

  // Result registers load only on the FIX cycle and hold until the next result.
  registerNbits #(.N(N)) u_quo_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en & out_we),
    .i_d   (quo_res),
    .o_q   (o_quotient)
  );

  registerNbits #(.N(N)) u_rem_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en & out_we),
    .i_d   (rem_res),
    .o_q   (o_remainder)
  );

  registerNbits #(.N(1)) u_dz_reg (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en & out_we),
    .i_d   (dz_q),
    .o_q   (o_div_by_zero)
  );

  assign o_valid = valid_q;
  assign o_busy  = (state_q != ST_IDLE);

endmodule
